// File: rtl/write_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : write_arbiter_ctrl
// Description : Round-robin write scheduler for the 16-port write arbiter.
//               Grants one requesting port at a time and holds the grant for a
//               whole packet. A grant is cut after MAX_BEATS accepted beats so
//               that no port can starve the others. It drives select/enable
//               into the channel selecter so the granted port's data reaches
//               the SRAM write path.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous reset, active low
//               wr_req       - per-port request, high while beats are pending
//               wr_last      - per-port flag: current beat is the packet's last
//               sram_ready   - SRAM write path accepts a beat this cycle
//               grant        - one-hot registered grant, zero when idle
//               select       - binary index of the granted port
//               enable       - high while a grant is active
//               beat_accept  - enable & sram_ready (combinational)
//               pkt_done     - one-cycle pulse after a grant ends normally
//               pkt_abort    - one-cycle pulse after a grant ends by withdrawal
// Revision    : 1.0 - initial release
// ============================================================================
module write_arbiter_ctrl #(
    parameter int NUM_OF_PORTS = 16,
    parameter int SEL_WIDTH    = 4,
    parameter int MAX_BEATS    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_OF_PORTS-1:0] wr_req,
    input  logic [NUM_OF_PORTS-1:0] wr_last,
    input  logic                    sram_ready,
    output logic [NUM_OF_PORTS-1:0] grant,
    output logic [SEL_WIDTH-1:0]    select,
    output logic                    enable,
    output logic                    beat_accept,
    output logic                    pkt_done,
    output logic                    pkt_abort
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    // Count value at which the beat being accepted is the last one allowed.
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(MAX_BEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]              r_state;
    logic [SEL_WIDTH-1:0]    r_select;
    logic [SEL_WIDTH-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic [NUM_OF_PORTS-1:0] r_grant;
    logic                    r_pkt_done;
    logic                    r_pkt_abort;

    logic                    w_busy;
    logic                    w_accept;
    logic                    w_end_normal;
    logic                    w_end_abort;
    logic                    w_end;
    logic                    w_any_req;
    logic [SEL_WIDTH-1:0]    w_next_ptr;
    logic [SEL_WIDTH-1:0]    w_scan_ptr;
    logic [SEL_WIDTH-1:0]    w_winner;
    logic [NUM_OF_PORTS-1:0] w_winner_onehot;

    assign w_busy     = (r_state == BUSY);
    assign w_accept   = w_busy & sram_ready;
    assign w_any_req  = |wr_req;
    assign w_next_ptr = r_select + 1'b1;

    // A beat accepted together with a request drop is still a normal beat;
    // withdrawal only counts as an abort while the SRAM is stalling.
    assign w_end_normal = w_accept & (wr_last[r_select] | (r_beat_cnt == c_last_cnt));
    assign w_end_abort  = w_busy & ~sram_ready & ~wr_req[r_select];
    assign w_end        = w_end_normal | w_end_abort;

    // At end-of-grant the scan starts just past the finishing port, so that
    // port gets lowest priority in the back-to-back handover.
    assign w_scan_ptr = w_busy ? w_next_ptr : r_rr_ptr;

    // First requester found scanning w_scan_ptr, w_scan_ptr+1, ... with
    // natural wrap. Descending loop so the nearest offset is written last.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_OF_PORTS - 1; i >= 0; i--) begin
            logic [SEL_WIDTH-1:0] v_idx;
            v_idx = w_scan_ptr + i[SEL_WIDTH-1:0];
            if (wr_req[v_idx]) begin
                w_winner = v_idx;
            end
        end
    end

    assign w_winner_onehot = {{(NUM_OF_PORTS-1){1'b0}}, 1'b1} << w_winner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_select    <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_grant     <= '0;
            r_pkt_done  <= 1'b0;
            r_pkt_abort <= 1'b0;
        end else begin
            r_pkt_done  <= w_end_normal;
            r_pkt_abort <= w_end_abort;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= BUSY;
                        r_select   <= w_winner;
                        r_grant    <= w_winner_onehot;
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    if (w_end) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                        if (w_any_req) begin
                            r_select <= w_winner;
                            r_grant  <= w_winner_onehot;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= '0;
                        end
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign select      = r_select;
    assign enable      = w_busy;
    assign beat_accept = w_accept;
    assign pkt_done    = r_pkt_done;
    assign pkt_abort   = r_pkt_abort;

endmodule
`default_nettype wire

// File: tb/tb_write_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_arbiter_ctrl
// Description : Self-checking bench for write_arbiter_ctrl. Cycle table for
//               single-port, stall, handover and abort behaviour, then
//               hand-written sequences for reset mid-packet, full rotation
//               and forced rotation at the burst cap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_arbiter_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] wr_req;
    logic [15:0] wr_last;
    logic        sram_ready;
    logic [15:0] grant;
    logic [3:0]  select;
    logic        enable;
    logic        beat_accept;
    logic        pkt_done;
    logic        pkt_abort;

    int n_tests;
    int n_fail;

    write_arbiter_ctrl #(
        .NUM_OF_PORTS(16),
        .SEL_WIDTH   (4),
        .MAX_BEATS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_last    (wr_last),
        .sram_ready (sram_ready),
        .grant      (grant),
        .select     (select),
        .enable     (enable),
        .beat_accept(beat_accept),
        .pkt_done   (pkt_done),
        .pkt_abort  (pkt_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic [15:0] last;
        logic        rdy;
        logic [15:0] exp_grant;
        logic [3:0]  exp_sel;
        logic        exp_en;
        logic        exp_acc;
        logic        exp_done;
        logic        exp_abort;
    } vec_t;

    vec_t vecs[20];
    int   exp_port[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        wr_req     = '0;
        wr_last    = '0;
        sram_ready = 1'b0;

        //            req      last     rdy  grant    sel  en   acc  done abort
        vecs[0]  = '{16'h0020, 16'h0000, 1, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0020, 16'h0000, 1, 16'h0020, 5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h0020, 16'h0000, 1, 16'h0020, 5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000, 16'h0020, 1, 16'h0020, 5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h0000, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h00A0, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h00A0, 16'h0000, 1, 16'h0080, 7, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'h00A0, 16'h0080, 0, 16'h0080, 7, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h00A0, 16'h0000, 0, 16'h0080, 7, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h00A0, 16'h0080, 1, 16'h0080, 7, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'h0020, 16'h0020, 1, 16'h0020, 5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'h0000, 16'h0000, 0, 16'h0020, 5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{16'h0000, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{16'h0008, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{16'h0008, 16'h0000, 1, 16'h0008, 3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{16'h0002, 16'h0000, 0, 16'h0008, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{16'h0002, 16'h0000, 0, 16'h0002, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{16'h0000, 16'h0000, 0, 16'h0002, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{16'h0000, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{16'h0000, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Burst-cap order: port 2 has 20 beats, port 9 sends 1-beat packets.
        for (int j = 0; j < 8; j++)  exp_port[j] = 2;
        exp_port[8] = 9;
        for (int j = 9; j < 17; j++) exp_port[j] = 2;
        exp_port[17] = 9;
        for (int j = 18; j < 22; j++) exp_port[j] = 2;
        exp_port[22] = 9;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("reset_grant",  32'(grant),     32'h0);
        check("reset_select", 32'(select),    32'h0);
        check("reset_enable", 32'(enable),    32'h0);
        check("reset_done",   32'(pkt_done),  32'h0);
        check("reset_abort",  32'(pkt_abort), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- cycle table ----------------
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wr_req     = vecs[k].req;
            wr_last    = vecs[k].last;
            sram_ready = vecs[k].rdy;
            #1;
            check($sformatf("v%0d_grant", k), 32'(grant),       32'(vecs[k].exp_grant));
            check($sformatf("v%0d_en", k),    32'(enable),      32'(vecs[k].exp_en));
            check($sformatf("v%0d_acc", k),   32'(beat_accept), 32'(vecs[k].exp_acc));
            check($sformatf("v%0d_done", k),  32'(pkt_done),    32'(vecs[k].exp_done));
            check($sformatf("v%0d_abort", k), 32'(pkt_abort),   32'(vecs[k].exp_abort));
            if (vecs[k].exp_en)
                check($sformatf("v%0d_sel", k), 32'(select), 32'(vecs[k].exp_sel));
        end

        // ---------------- reset mid-packet (port 11, beat 2) ----------------
        @(negedge clk);
        wr_req     = 16'h0800;
        wr_last    = 16'h0000;
        sram_ready = 1'b1;
        @(negedge clk);
        #1;
        check("p11_grant", 32'(grant),  32'h0800);
        check("p11_sel",   32'(select), 32'd11);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_grant",  32'(grant),     32'h0);
        check("rstmid_select", 32'(select),    32'h0);
        check("rstmid_enable", 32'(enable),    32'h0);
        check("rstmid_done",   32'(pkt_done),  32'h0);
        check("rstmid_abort",  32'(pkt_abort), 32'h0);

        // ---------------- full rotation from port 0 after reset ----------------
        @(negedge clk);
        rst        = 1'b1;
        wr_req     = 16'hFFFF;
        wr_last    = 16'hFFFF;
        sram_ready = 1'b1;
        #1;
        check("rot_idle_en",   32'(enable),    32'h0);
        check("rot_idle_done", 32'(pkt_done),  32'h0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rot%0d_sel", i),   32'(select),   32'(i % 16));
            check($sformatf("rot%0d_grant", i), 32'(grant),    32'(16'h0001 << (i % 16)));
            check($sformatf("rot%0d_en", i),    32'(enable),   32'h1);
            check($sformatf("rot%0d_done", i),  32'(pkt_done), 32'(i > 0));
        end
        @(negedge clk);
        wr_req = 16'h0000;
        #1;
        check("rot_tail_sel", 32'(select), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("rot_drain_en", 32'(enable), 32'h0);

        // ---------------- forced rotation at the burst cap ----------------
        begin
            int rem2;
            rem2 = 20;
            @(negedge clk);
            wr_req     = 16'h0204;
            wr_last    = 16'h0200;
            sram_ready = 1'b1;
            #1;
            check("cap_idle_en", 32'(enable), 32'h0);
            for (int j = 0; j < 23; j++) begin
                @(negedge clk);
                wr_req  = ((rem2 > 0) ? 16'h0004 : 16'h0000) | ((j < 22) ? 16'h0200 : 16'h0000);
                wr_last = 16'h0200 | ((rem2 == 1) ? 16'h0004 : 16'h0000);
                #1;
                check($sformatf("cap%0d_sel", j), 32'(select),      32'(exp_port[j]));
                check($sformatf("cap%0d_acc", j), 32'(beat_accept), 32'h1);
                check($sformatf("cap%0d_done", j), 32'(pkt_done),
                      32'((j > 0) && (exp_port[j-1] != exp_port[j])));
                if (exp_port[j] == 2) rem2--;
            end
            @(negedge clk);
            wr_req  = 16'h0000;
            wr_last = 16'h0000;
            #1;
            check("cap_end_en",   32'(enable),   32'h0);
            check("cap_end_done", 32'(pkt_done), 32'h1);
            check("cap_rem2",     32'(rem2),     32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/write_arbiter_ctrl.md
Name: write_arbiter_ctrl

Overview:
- Round-robin write scheduler for the 16-port write arbiter.
- Watches per-port write requests and packet-last flags, and grants one port at a time.
- Drives select/enable into the channel selecter so the granted port's 256-bit data reaches the SRAM write path.
- Holds a grant for a whole packet, capped at a maximum burst so that no port starves the others.

Parameters:
- num_of_ports, 16, number of write requesters (power of two).
- sel_width, 4, width of select; equals log2(num_of_ports).
- max_beats, 8, maximum accepted beats per grant before forced rotation (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_req  input  num_of_ports  per-port request; held high while the port has beats pending.
- wr_last  input  num_of_ports  per-port flag marking the current beat as the packet's final beat.
- sram_ready  input  1  SRAM write path accepts a beat this cycle.
- grant  output  num_of_ports  one-hot registered grant; all zero when idle.
- select  output  sel_width  binary index of the granted port, to channel selecter select.
- enable  output  1  to channel selecter enable; high while a grant is active.
- beat_accept  output  1  combinational: enable & sram_ready; a beat transfers this cycle.
- pkt_done  output  1  registered one-cycle pulse after a grant ends normally (last or max_beats).
- pkt_abort  output  1  registered one-cycle pulse after a grant ends by request withdrawal.

Behaviour:
- Reset (rst low, async): state IDLE, grant=0, select=0, enable=0, rr_ptr=0, beat_cnt=0, pkt_done=0, pkt_abort=0.
- State register: IDLE and BUSY only.
  - enable = (state==BUSY).
  - grant = one-hot of select in BUSY, else 0.
- Winner function, combinational: first set bit of wr_req scanning rr_ptr, rr_ptr+1, ... modulo num_of_ports.
- IDLE:
  - If |wr_req, next edge: state=BUSY, select=winner, beat_cnt=0.
  - Latency is one cycle from request to enable.
  - Otherwise remain IDLE.
- BUSY, beat accepted (sram_ready=1): beat_cnt increments.
  - End-of-grant if wr_last[select]=1, or if beat_cnt+1==max_beats.
- BUSY, no beat accepted (sram_ready=0): grant holds and beat_cnt holds. wr_last is ignored.
- BUSY, abort: wr_req[select]=0 while sram_ready=0 ends the grant as an abort.
  - A request drop in the same cycle as an accepted beat is treated as a normal beat.
- End-of-grant, on the same edge:
  - rr_ptr = (select+1) mod num_of_ports.
  - pkt_done or pkt_abort pulses next cycle.
- Back-to-back: at end-of-grant, the winner is recomputed with the new rr_ptr over current wr_req.
  - If any request exists: stay BUSY and load the new select. There is no idle bubble.
  - Else go to IDLE.
  - The just-finished port is lowest priority. It is re-granted only if it is the sole requester.
- Forced rotation at max_beats: the port's packet continues on its next grant. beat_cnt restarts at 0.
- Arithmetic:
  - beat_cnt width is clog2(max_beats+1).
  - rr_ptr and select are sel_width wide and wrap naturally from num_of_ports-1 to 0.
- Simultaneous events:
  - Last beat plus max_beats reached in the same beat: pkt_done fires once.
  - Last beat plus another port's new request: the handover happens that edge.
- Reset mid-packet:
  - All outputs clear immediately.
  - The pending packet is discarded with no pulse. Requesters must re-arbitrate.
- Select is stable for the whole grant. Select changes only on end-of-grant edges.

Test Plan:
- Port 5 only, wr_req[5]=1, sram_ready=1, last on beat 3 -> enable one cycle after request; select=5 for exactly 3 accepted beats; pkt_done pulse; rr_ptr=6; IDLE.
- All 16 requesting, each 1-beat packets (wr_last=all 1), sram_ready=1 -> grants 0,1,...,15,0 on consecutive cycles; no idle bubble; 16 pkt_done pulses.
- Port 2 with 20-beat packet, max_beats=8, port 9 also requesting -> grant order 2(8 beats), 9, 2(8), 9..., then 2(4); beat_cnt never exceeds 8.
- Port 7 granted, sram_ready toggling 1,0,0,1 with last on 2nd accepted beat -> beat_cnt holds during stalls; grant ends only after the 2nd accepted beat.
- Port 3 granted, drops wr_req[3] with sram_ready=0 after 1 beat -> pkt_abort pulse; rr_ptr=4; next requester granted or IDLE.
- rst low mid-packet at beat 2 of port 11 -> grant, select, enable cleared asynchronously; no pulses; after release, arbitration restarts from port 0.
